// File: rtl/clk_div_to_one.sv
// Divides clk_in down to a 50% duty square wave at CLK_OUT_HZ (default 100 MHz -> 1 Hz).
// Optional `CLK_DIV_TO_ONE_TICK_EN adds tick_out, a one-cycle strobe coincident with each clk_out rise.
module clk_div_to_one #(
    parameter int CLK_IN_HZ  = 100_000_000,
    parameter int CLK_OUT_HZ = 1
) (
    input  logic clk_in,
    input  logic rst,
    output logic clk_out
`ifdef CLK_DIV_TO_ONE_TICK_EN
    ,
    output logic tick_out
`endif
);

    // Guard the division so a bad CLK_OUT_HZ reaches the elaboration check below
    localparam int HALF = (CLK_OUT_HZ > 0) ? CLK_IN_HZ / (2 * CLK_OUT_HZ) : 0;
    localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] LAST = CW'((HALF > 0) ? HALF - 1 : 0);

    generate
        if (CLK_OUT_HZ <= 0 || HALF < 1) begin : g_bad_params
            $error("clk_div_to_one: CLK_OUT_HZ must be > 0 and CLK_IN_HZ >= 2*CLK_OUT_HZ");
        end
    endgenerate

    logic [CW-1:0] cnt_reg;
    logic          at_last;
    logic          over_range;

    assign at_last    = (cnt_reg == LAST);
    assign over_range = (cnt_reg > LAST);

    // Unreachable counts recover to 0 without disturbing the output phase
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
            clk_out <= 1'b0;
        end else if (at_last) begin
            cnt_reg <= '0;
            clk_out <= ~clk_out;
        end else if (over_range) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

`ifdef CLK_DIV_TO_ONE_TICK_EN
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            tick_out <= 1'b0;
        end else begin
            tick_out <= at_last && !clk_out;
        end
    end
`endif

endmodule

// File: tb/tb_clk_div_to_one.sv
// Randomized bench for clk_div_to_one: HALF=5 and HALF=1 instances against an edge-count model.
// Tick checks are compiled in when `CLK_DIV_TO_ONE_TICK_EN is defined.
module tb_clk_div_to_one;

    localparam int H  = 5;
    localparam int H1 = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clk_out;
    logic clk_out_h1;
`ifdef CLK_DIV_TO_ONE_TICK_EN
    logic tick_out;
    logic tick_out_h1;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int n_edges  = 0;

    always #5 clk = ~clk;

    clk_div_to_one #(.CLK_IN_HZ(100), .CLK_OUT_HZ(10)) dut (
        .clk_in  (clk),
        .rst     (rst),
        .clk_out (clk_out)
`ifdef CLK_DIV_TO_ONE_TICK_EN
        ,
        .tick_out(tick_out)
`endif
    );

    clk_div_to_one #(.CLK_IN_HZ(2), .CLK_OUT_HZ(1)) dut_h1 (
        .clk_in  (clk),
        .rst     (rst),
        .clk_out (clk_out_h1)
`ifdef CLK_DIV_TO_ONE_TICK_EN
        ,
        .tick_out(tick_out_h1)
`endif
    );

    // Reference: number of clk_in rising edges seen since reset was released
    always @(posedge clk or posedge rst) begin
        if (rst) n_edges <= 0;
        else     n_edges <= n_edges + 1;
    end

    function automatic int exp_out(input int n, input int half);
        return (rst) ? 0 : ((n / half) % 2);
    endfunction

    function automatic int exp_tick(input int n, input int half);
        return (rst) ? 0 : ((n % (2 * half)) == half ? 1 : 0);
    endfunction

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t edges=%0d got=%0d expected=%0d", tag, $time, n_edges, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_eq("clk_out", int'(clk_out), exp_out(n_edges, H));
        check_eq("cnt", int'(dut.cnt_reg), rst ? 0 : n_edges % H);
        check_eq("clk_out_h1", int'(clk_out_h1), exp_out(n_edges, H1));
`ifdef CLK_DIV_TO_ONE_TICK_EN
        check_eq("tick_out", int'(tick_out), exp_tick(n_edges, H));
        check_eq("tick_out_h1", int'(tick_out_h1), exp_tick(n_edges, H1));
`endif
    endtask

    initial begin
        int run_len;
        int hold;
        int guard;

        // Reset held 100 ns; outputs must stay low throughout
        repeat (10) step();
        rst = 1'b0;
        $display("reset released t=%0t", $time);

        // 20 full output periods from release
        repeat (200) step();
        $display("segment 0: 200 cycles, errors so far %0d", n_errors);

        for (int seg = 1; seg <= 8; seg++) begin
            run_len = $urandom_range(15, 60);
            repeat (run_len) step();

            // Line up on a high phase, then reset between edges
            guard = 0;
            while (exp_out(n_edges, H) == 0 && guard < 20) begin
                step();
                guard++;
            end
            check_eq("high_phase_found", (guard < 20) ? 1 : 0, 1);
            check_eq("clk_out_before_rst", int'(clk_out), 1);
            @(posedge clk);
            #($urandom_range(1, 3));
            rst = 1'b1;
            #1;
            check_eq("async_rst_clk_out", int'(clk_out), 0);
            check_eq("async_rst_clk_out_h1", int'(clk_out_h1), 0);
`ifdef CLK_DIV_TO_ONE_TICK_EN
            check_eq("async_rst_tick", int'(tick_out), 0);
`endif
            hold = $urandom_range(1, 3);
            repeat (hold) step();
            rst = 1'b0;
            $display("segment %0d: ran %0d cycles, reset held %0d, errors so far %0d",
                     seg, run_len, hold, n_errors);
        end

        repeat (30) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
